// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, status bit positions and baud helper
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   localparam int ST_EMPTY     = 0;
   localparam int ST_FULL      = 1;
   localparam int ST_BUSY      = 2;
   localparam int ST_OVERFLOW  = 3;
   localparam int ST_LEVEL_LSB = 8;

   // Integer division truncates, so odd ratios round the bit period down.
   function automatic int clks_per_bit(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with level count and gated push/pop
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wr_data,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   // full/empty come from the level register only, so a push is judged
   // against the state before any same-cycle pop.
   assign full    = (level == LVL_FULL);
   assign empty   = (level == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   // Storage array; contents are don't-care until written.
   always_ff @(posedge CLK) begin
      if (push_ok) mem[wr_ptr] <= wr_data;
   end

   // Pointers wrap naturally at the power-of-two depth; level spans 0..DEPTH.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_queue.sv
// rtl/uart_tx_queue.sv - memory-mapped UART transmitter with byte FIFO and status word
module uart_tx_queue
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 12000000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        wr_en,
   input  logic [15:0] wr_data,
   input  logic        clr_overflow,
   output logic [15:0] status,
   output logic        full,
   output logic        empty,
   output logic        busy,
   output logic        TX
);

   localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
   localparam int TW  = $clog2(CPB);
   localparam int LW  = $clog2(FIFO_DEPTH) + 1;
   localparam logic [TW-1:0] TMAX = TW'(CPB - 1);

   uart_state_t   state, state_nx;
   logic [TW-1:0] timer, timer_nx;
   logic [2:0]    bit_idx, bit_idx_nx;
   logic [7:0]    shift, shift_nx;
   logic          tx_nx;
   logic          pop;
   logic          overflow;
   logic [7:0]    head;
   logic [LW-1:0] level;
   logic          unused_hi;

   // Only the low byte of a store is transmitted.
   assign unused_hi = ^wr_data[15:8];

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .push    (wr_en),
      .pop     (pop),
      .wr_data (wr_data[7:0]),
      .rd_data (head),
      .full    (full),
      .empty   (empty),
      .level   (level)
   );

   // Serializer next-state; TX follows the current state one clock later.
   always_comb begin
      state_nx   = state;
      timer_nx   = timer;
      bit_idx_nx = bit_idx;
      shift_nx   = shift;
      pop        = 1'b0;
      tx_nx      = 1'b1;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop      = 1'b1;
               shift_nx = head;
               timer_nx = '0;
               state_nx = START;
            end
         end
         START: begin
            tx_nx = 1'b0;
            if (timer == TMAX) begin
               timer_nx   = '0;
               bit_idx_nx = '0;
               state_nx   = DATA;
            end else begin
               timer_nx = timer + 1'b1;
            end
         end
         DATA: begin
            tx_nx = shift[0];
            if (timer == TMAX) begin
               timer_nx = '0;
               if (bit_idx == 3'd7) begin
                  state_nx = STOP;
               end else begin
                  shift_nx   = shift >> 1;
                  bit_idx_nx = bit_idx + 1'b1;
               end
            end else begin
               timer_nx = timer + 1'b1;
            end
         end
         STOP: begin
            if (timer == TMAX) begin
               timer_nx = '0;
               state_nx = IDLE;
            end else begin
               timer_nx = timer + 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Serializer registers; reset forces the line idle immediately.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state   <= IDLE;
         timer   <= '0;
         bit_idx <= '0;
         shift   <= '0;
         TX      <= 1'b1;
      end else begin
         state   <= state_nx;
         timer   <= timer_nx;
         bit_idx <= bit_idx_nx;
         shift   <= shift_nx;
         TX      <= tx_nx;
      end
   end

   // Sticky overflow; a drop in the same cycle as a clear wins.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)                overflow <= 1'b0;
      else if (wr_en && full)    overflow <= 1'b1;
      else if (clr_overflow)     overflow <= 1'b0;
   end

   assign busy = (state != IDLE);

   // Status word packed from registered state only.
   always_comb begin
      status                       = '0;
      status[ST_EMPTY]             = empty;
      status[ST_FULL]              = full;
      status[ST_BUSY]              = busy;
      status[ST_OVERFLOW]          = overflow;
      status[ST_LEVEL_LSB +: LW]   = level;
   end

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb/tb_uart_tx_queue.sv - self-checking bench for uart_tx_queue
module tb_uart_tx_queue;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        wr_en = 1'b0;
   logic [15:0] wr_data = '0;
   logic        clr_overflow = 1'b0;
   logic [15:0] status;
   logic        full, empty, busy, TX;

   int errors = 0;
   int checks = 0;

   logic [7:0] exp_q [$];

   typedef struct {
      logic [15:0] wdata;
      logic [7:0]  exp_byte;
      logic [15:0] exp_status;
   } vec_t;
   vec_t vecs [4];

   bit         mon_ab;
   logic [7:0] mon_byte;

   uart_tx_queue #(
      .CLK_HZ     (1000),
      .BAUD       (100),
      .FIFO_DEPTH (16)
   ) dut (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .clr_overflow (clr_overflow),
      .status       (status),
      .full         (full),
      .empty        (empty),
      .busy         (busy),
      .TX           (TX)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic mon_wait(input int n);
      while (n > 0 && !mon_ab) begin
         @(negedge CLK);
         if (RST_N !== 1'b1) mon_ab = 1'b1;
         n--;
      end
   endtask

   task automatic wait_drain(input string name);
      bit done;
      done = 1'b0;
      for (int k = 0; k < 3000 && !done; k++) begin
         @(negedge CLK);
         if (!busy && empty && exp_q.size() == 0) done = 1'b1;
      end
      check(name, done, 1'b1);
   endtask

   // Frame monitor: samples mid-bit and scores received bytes against exp_q.
   initial begin
      forever begin
         @(negedge CLK);
         if (RST_N === 1'b1 && TX === 1'b0) begin
            mon_ab = 1'b0;
            mon_wait(5);
            if (!mon_ab) check("start_bit", TX, 1'b0);
            for (int i = 0; i < 8; i++) begin
               mon_wait(10);
               mon_byte[i] = TX;
            end
            mon_wait(10);
            if (!mon_ab) begin
               check("stop_bit", TX, 1'b1);
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL frame_byte: got unexpected frame %0h expected none", mon_byte);
               end else begin
                  check("frame_byte", mon_byte, exp_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit bad;
      bit found;

      vecs[0] = '{16'hAB55, 8'h55, 16'h0100};
      vecs[1] = '{16'h00FF, 8'hFF, 16'h0100};
      vecs[2] = '{16'h1200, 8'h00, 16'h0100};
      vecs[3] = '{16'hFFA5, 8'hA5, 16'h0100};

      // Reset state and idle line
      RST_N = 1'b0;
      repeat (3) @(negedge CLK);
      check("reset_tx", TX, 1'b1);
      check("reset_status", status, 16'h0001);
      RST_N = 1'b1;
      bad = 1'b0;
      repeat (50) begin
         @(negedge CLK);
         if (TX !== 1'b1) bad = 1'b1;
      end
      check("idle_tx_50", bad, 1'b0);

      // Latency and frame timing of 0x41
      @(negedge CLK);
      wr_en = 1'b1;
      wr_data = 16'h0041;
      exp_q.push_back(8'h41);
      @(posedge CLK);
      #1 wr_en = 1'b0;
      check("lat_n0_status", status, 16'h0100);
      @(posedge CLK);
      #1 check("lat_n1_tx", TX, 1'b1);
      check("lat_n1_busy", busy, 1'b1);
      @(posedge CLK);
      #1 check("lat_n2_tx", TX, 1'b0);
      repeat (98) @(posedge CLK);
      #1 check("busy_n100", busy, 1'b1);
      @(posedge CLK);
      #1 check("busy_n101", busy, 1'b0);
      check("tx_n101", TX, 1'b1);
      wait_drain("drain_41");

      // Table of single writes; upper byte must never reach the line
      for (int v = 0; v < 4; v++) begin
         @(negedge CLK);
         wr_en = 1'b1;
         wr_data = vecs[v].wdata;
         exp_q.push_back(vecs[v].exp_byte);
         @(negedge CLK);
         wr_en = 1'b0;
         check("tbl_status", status, vecs[v].exp_status);
         wait_drain("tbl_drain");
      end

      // 17 back-to-back writes fill the FIFO, the 18th is dropped
      for (int i = 0; i < 18; i++) begin
         @(negedge CLK);
         if (i == 17) check("fill_status", status, 16'h1006);
         wr_en = 1'b1;
         wr_data = 16'(i);
         if (i < 17) exp_q.push_back(8'(i));
      end
      @(negedge CLK);
      wr_en = 1'b0;
      check("overflow_status", status, 16'h100E);

      @(negedge CLK);
      clr_overflow = 1'b1;
      @(negedge CLK);
      clr_overflow = 1'b0;
      check("clr_status", status, 16'h1006);

      // Write on the IDLE pop cycle while full is rejected
      found = 1'b0;
      for (int k = 0; k < 200 && !found; k++) begin
         @(negedge CLK);
         if (!busy) found = 1'b1;
      end
      check("idle_gap_found", found, 1'b1);
      check("idle_gap_status", status, 16'h1002);
      wr_en = 1'b1;
      wr_data = 16'h00EE;
      @(negedge CLK);
      wr_en = 1'b0;
      check("pop_drop_status", status, 16'h0F0C);
      @(negedge CLK);
      clr_overflow = 1'b1;
      @(negedge CLK);
      clr_overflow = 1'b0;
      check("clr2_status", status, 16'h0F04);
      wait_drain("drain_burst");

      // Reset during DATA bit 3 aborts the frame and discards the queue
      @(negedge CLK);
      wr_en = 1'b1;
      wr_data = 16'h0000;
      @(negedge CLK);
      wr_data = 16'h0033;
      @(negedge CLK);
      wr_en = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         if (TX === 1'b0) found = 1'b1;
         else @(negedge CLK);
      end
      check("abort_start_seen", found, 1'b1);
      repeat (45) @(posedge CLK);
      #2 RST_N = 1'b0;
      #1 check("abort_tx", TX, 1'b1);
      check("abort_status", status, 16'h0001);
      @(negedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
      bad = 1'b0;
      repeat (20) begin
         @(negedge CLK);
         if (TX !== 1'b1 || !empty) bad = 1'b1;
      end
      check("abort_discard", bad, 1'b0);

      @(negedge CLK);
      wr_en = 1'b1;
      wr_data = 16'h007E;
      exp_q.push_back(8'h7E);
      @(negedge CLK);
      wr_en = 1'b0;
      wait_drain("drain_7e");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
